shifter_pipe: RTL and testbench

- Four-stage pipelined 16-bit shifter/rotator for the execute datapath; one log-shifter level per stage, with amounts 1, 2, 4 and 8.
- Consumes operand, shift count and opcode from decode/issue over a valid/ready handshake.
- Delivers the result to ALU writeback over a second valid/ready handshake.
- Sustains one operation per cycle, with full backpressure and bubble collapse.

---
 rtl/shifter_pipe_pkg.sv | 25 ++
 rtl/shifter_pipe_level.sv | 33 +++
 rtl/shifter_pipe.sv | 115 +++++++++++
 tb/tb_shifter_pipe.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shifter_pipe_pkg
// Description : Opcode encodings and width helpers shared by the shifter pipe.
// Revision    : 1.0 - initial release
// ============================================================================
package shifter_pipe_pkg;

    localparam int WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        OP_ROL = 2'b00,
        OP_SLL = 2'b01,
        OP_ROR = 2'b10,
        OP_SRL = 2'b11
    } op_e;

    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

    localparam int CNT_W_DEF = cnt_width(WIDTH_DEF);

endpackage
`default_nettype wire

// File: rtl/shifter_pipe_level.sv
`default_nettype none
// ============================================================================
// Module      : shift_level
// Description : One log-shifter level: shifts/rotates by AMT when enabled.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_level
    import shifter_pipe_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int AMT   = 1
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_en,
    input  logic [1:0]       i_op,
    output logic [WIDTH-1:0] o_data
);

    always_comb begin
        o_data = i_data;
        if (i_en) begin
            case (i_op)
                OP_ROL:  o_data = {i_data[WIDTH-AMT-1:0], i_data[WIDTH-1:WIDTH-AMT]};
                OP_SLL:  o_data = {i_data[WIDTH-AMT-1:0], {AMT{1'b0}}};
                OP_ROR:  o_data = {i_data[AMT-1:0], i_data[WIDTH-1:AMT]};
                OP_SRL:  o_data = {{AMT{1'b0}}, i_data[WIDTH-1:AMT]};
                default: o_data = i_data;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/shifter_pipe.sv
`default_nettype none
// ============================================================================
// Module      : shifter_pipe
// Description : Pipelined shifter/rotator, one log-shift level per stage, with
//               valid/ready on both sides and bubble collapse.
// Revision    : 1.0 - initial release
// ============================================================================
module shifter_pipe
    import shifter_pipe_pkg::*;
#(
    parameter  int WIDTH = WIDTH_DEF,
    localparam int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CNT_W-1:0] in_cnt,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    localparam int NSTAGE = CNT_W;
    localparam int LAST   = NSTAGE - 1;

    logic [NSTAGE-1:0] r_valid;
    logic [WIDTH-1:0]  r_data [NSTAGE];
    logic [CNT_W-1:0]  r_cnt  [NSTAGE];
    logic [1:0]        r_op   [NSTAGE];

    logic [NSTAGE-1:0] w_accept;
    logic [NSTAGE-1:0] w_vin;
    logic [NSTAGE-1:0] w_en;
    logic [WIDTH-1:0]  w_pre  [NSTAGE];
    logic [WIDTH-1:0]  w_din  [NSTAGE];
    logic [CNT_W-1:0]  w_cin  [NSTAGE];
    logic [1:0]        w_oin  [NSTAGE];

    // A stage can take new contents when empty or when everything downstream
    // of it can move; resolving from the output end gives bubble collapse.
    always_comb begin
        w_accept       = '0;
        w_accept[LAST] = !r_valid[LAST] | out_ready;
        for (int k = LAST - 1; k >= 0; k--) begin
            w_accept[k] = !r_valid[k] | w_accept[k+1];
        end
    end

    always_comb begin
        w_vin    = '0;
        w_en     = '0;
        w_vin[0] = in_valid;
        w_pre[0] = in_data;
        w_cin[0] = in_cnt;
        w_oin[0] = in_op;
        for (int k = 1; k < NSTAGE; k++) begin
            w_vin[k] = r_valid[k-1];
            w_pre[k] = r_data[k-1];
            w_cin[k] = r_cnt[k-1];
            w_oin[k] = r_op[k-1];
        end
        // Stage k applies the 2^k shift selected by count bit k.
        for (int k = 0; k < NSTAGE; k++) begin
            w_en[k] = w_cin[k][k];
        end
    end

    generate
        for (genvar k = 0; k < NSTAGE; k++) begin : g_level
            shift_level #(
                .WIDTH (WIDTH),
                .AMT   (1 << k)
            ) u_level (
                .i_data (w_pre[k]),
                .i_en   (w_en[k]),
                .i_op   (w_oin[k]),
                .o_data (w_din[k])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            for (int k = 0; k < NSTAGE; k++) begin
                r_data[k] <= '0;
                r_cnt[k]  <= '0;
                r_op[k]   <= 2'b00;
            end
        end else begin
            for (int k = 0; k < NSTAGE; k++) begin
                if (w_accept[k]) begin
                    r_valid[k] <= w_vin[k];
                    // Payload only moves with a valid op so idle stages stay quiet.
                    if (w_vin[k]) begin
                        r_data[k] <= w_din[k];
                        r_cnt[k]  <= w_cin[k];
                        r_op[k]   <= w_oin[k];
                    end
                end
            end
        end
    end

    assign in_ready  = w_accept[0];
    assign out_valid = r_valid[LAST];
    assign out_data  = r_data[LAST];
    assign busy      = |r_valid;

endmodule
`default_nettype wire

// File: tb/tb_shifter_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_shifter_pipe
// Description : Self-checking bench for shifter_pipe against an arithmetic
//               reference model and an in-flight scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shifter_pipe;
    import shifter_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [3:0]  in_cnt;
    logic [1:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int n_out    = 0;

    logic [15:0] exp_q[$];
    logic        prev_hold = 1'b0;
    logic [15:0] prev_data = '0;

    shifter_pipe #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_cnt    (in_cnt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Shift/rotate by plain arithmetic on a widened operand.
    function automatic logic [15:0] ref_model(input logic [15:0] d, input logic [3:0] c,
                                              input logic [1:0] op);
        logic [31:0] x;
        logic [31:0] r;
        int          n;
        x = {16'h0000, d};
        n = int'(c);
        case (op)
            2'b00:   r = (x << n) | (x >> (16 - n));
            2'b01:   r = x << n;
            2'b10:   r = (x >> n) | (x << (16 - n));
            default: r = x >> n;
        endcase
        return r[15:0];
    endfunction

    // Scoreboard: occupancy rules, held output under backpressure, in-order results.
    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            check("in_ready_rule", 32'(in_ready), 32'(out_ready | (exp_q.size() < 4)));
            check("busy_rule", 32'(busy), 32'(exp_q.size() != 0));
            if (prev_hold) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(out_data), 32'(prev_data));
            end
            prev_hold = out_valid & !out_ready;
            prev_data = out_data;
            if (out_valid & out_ready) begin
                n_out++;
                check("out_has_expect", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check("result", 32'(out_data), 32'(exp_q.pop_front()));
            end
            if (in_valid & in_ready) exp_q.push_back(ref_model(in_data, in_cnt, in_op));
        end
    end

    // Entered and left at posedge+1; drives one cycle and reports acceptance.
    task automatic drive(input logic v, input logic [15:0] d, input logic [3:0] c,
                         input logic [1:0] op, output logic acc);
        in_valid = v;
        in_data  = d;
        in_cnt   = c;
        in_op    = op;
        @(negedge clk);
        acc = v & in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d, input logic [3:0] c, input logic [1:0] op);
        logic acc;
        int   k;
        acc = 1'b0;
        k   = 0;
        while (!acc && k < 20) begin
            drive(1'b1, d, c, op, acc);
            k++;
        end
        in_valid = 1'b0;
        check("send_accepted", 32'(acc), 32'd1);
    endtask

    task automatic run_single(input string tag, input logic [15:0] d, input logic [3:0] c,
                              input logic [1:0] op, input logic [15:0] exp);
        int          lat;
        logic        got;
        logic [15:0] obs;
        send(d, c, op);
        lat = 0;
        got = 1'b0;
        obs = '0;
        while (!got && lat < 12) begin
            @(negedge clk);
            lat++;
            if (out_valid) begin
                got = 1'b1;
                obs = out_data;
            end
        end
        check({tag, "_latency"}, 32'(lat), 32'd4);
        check({tag, "_data"}, 32'(obs), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        logic acc;
        int   k;
        out_ready = 1'b1;
        k = 0;
        while ((busy || exp_q.size() != 0) && k < 20) begin
            drive(1'b0, 16'h0000, 4'h0, 2'b00, acc);
            k++;
        end
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        check("drain_not_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acc;
        int          base;
        int          sent;
        logic [15:0] bd [6];
        logic [3:0]  bc [6];
        logic [1:0]  bo [6];
        logic [15:0] exp_a;
        logic [15:0] exp_b;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_cnt    = '0;
        in_op     = 2'b00;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", 32'(out_data), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_single("ror_8001_1", 16'h8001, 4'd1, OP_ROR, 16'hC000);
        run_single("rol_1234_4", 16'h1234, 4'd4, OP_ROL, 16'h2341);
        run_single("srl_f000_12", 16'hF000, 4'd12, OP_SRL, 16'h000F);
        run_single("sll_0001_15", 16'h0001, 4'd15, OP_SLL, 16'h8000);
        run_single("ror_cnt0", 16'hA5C3, 4'd0, OP_ROR, 16'hA5C3);

        // Back-to-back sweep over every count and opcode.
        base = n_out;
        for (int op = 0; op < 4; op++) begin
            for (int c = 0; c < 16; c++) begin
                drive(1'b1, 16'($urandom), 4'(c), 2'(op), acc);
                check("sweep_in_ready", 32'(acc), 32'd1);
            end
        end
        in_valid = 1'b0;
        drain();
        check("sweep_count", 32'(n_out - base), 32'd64);

        // Backpressure: four accepts fill the pipe, output holds the first result.
        for (int i = 0; i < 6; i++) begin
            bd[i] = 16'($urandom);
            bc[i] = 4'($urandom);
            bo[i] = 2'($urandom);
        end
        exp_a     = ref_model(bd[0], bc[0], bo[0]);
        base      = n_out;
        sent      = 0;
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 40 && sent < 6; cyc++) begin
            if (cyc == 10) out_ready = 1'b1;
            drive(1'b1, bd[sent], bc[sent], bo[sent], acc);
            if (acc) sent++;
            if (cyc >= 4 && cyc <= 9) check("bp_held_first", 32'(out_data), 32'(exp_a));
            if (cyc == 9) check("bp_accepts_full", 32'(sent), 32'd4);
        end
        in_valid = 1'b0;
        drain();
        check("bp_delivered", 32'(n_out - base), 32'd6);

        // Bubble collapse: A lands in the last stage, B stops one behind it.
        out_ready = 1'b0;
        exp_a = ref_model(16'h1357, 4'd3, OP_ROL);
        exp_b = ref_model(16'hBEEF, 4'd9, OP_SRL);
        send(16'h1357, 4'd3, OP_ROL);
        drive(1'b0, 16'h0000, 4'h0, 2'b00, acc);
        drive(1'b0, 16'h0000, 4'h0, 2'b00, acc);
        send(16'hBEEF, 4'd9, OP_SRL);
        repeat (3) drive(1'b0, 16'h0000, 4'h0, 2'b00, acc);
        check("bubble_a_valid", 32'(out_valid), 32'd1);
        check("bubble_a_data", 32'(out_data), 32'(exp_a));
        check("bubble_busy", 32'(busy), 32'd1);
        check("bubble_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        drive(1'b0, 16'h0000, 4'h0, 2'b00, acc);
        out_ready = 1'b0;
        check("bubble_b_valid", 32'(out_valid), 32'd1);
        check("bubble_b_data", 32'(out_data), 32'(exp_b));
        drain();

        // Asynchronous reset with three operations in flight.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'($urandom), 4'($urandom), 2'($urandom), acc);
            check("rst_preload_accept", 32'(acc), 32'd1);
        end
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_data", 32'(out_data), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_single("post_rst_sll", 16'h00FF, 4'd8, OP_SLL, 16'hFF00);
        drain();

        // Random traffic with random backpressure.
        base = n_out;
        sent = 0;
        for (int i = 0; i < 1500; i++) begin
            out_ready = ($urandom % 4) != 0;
            drive(($urandom % 10) < 7, 16'($urandom), 4'($urandom), 2'($urandom), acc);
            if (acc) sent++;
        end
        in_valid = 1'b0;
        drain();
        check("random_delivered", 32'(n_out - base), 32'(sent));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
